// File: rtl/proc_fetch_unit.sv
// Fetch stage of the TinyRV1 pipeline.
// Owns the PC, issues in-order requests to a variable-latency instruction
// memory, buffers the responses in a small circular buffer and hands one
// {inst, pc} pair per valid/ready transfer to decode. Control-flow redirects
// flush the buffer and discard wrong-path responses that are still owed.
module proc_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_data,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        f2d_val,
  input  logic        f2d_rdy,
  output logic [31:0] f2d_inst,
  output logic [31:0] f2d_pc
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);

  // Architectural state
  logic [31:0]      pc_q, pc_d;
  logic [PW-1:0]    alloc_q, alloc_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  // Buffer payload
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  // Derived status
  logic [PW-1:0] count;
  logic [PW-1:0] outstanding;
  logic [PW:0]   occupancy;
  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] head_idx;
  logic          req_fire;
  logic          resp_fill;
  logic          resp_drop;
  logic          resp_drain;
  logic          pop;

  // Occupancy, handshakes and output muxing
  always_comb begin
    count       = alloc_q - head_q;
    outstanding = alloc_q - fill_q;
    occupancy   = {1'b0, count} + {1'b0, drop_cnt_q};
    alloc_idx   = alloc_q[IW-1:0];
    fill_idx    = fill_q[IW-1:0];
    head_idx    = head_q[IW-1:0];

    imemreq_val  = ~rst & ~redirect_val & (occupancy < DEPTH_W);
    imemreq_addr = pc_q;

    f2d_val  = filled_q[head_idx] & (count != '0) & ~redirect_val & ~rst;
    f2d_inst = inst_mem[head_idx];
    f2d_pc   = pc_mem[head_idx];

    req_fire = imemreq_val & imemreq_rdy;
    pop      = f2d_val & f2d_rdy;

    // A response is owed only if a wrong-path drop or a live request is pending;
    // anything else is an imem protocol violation and is ignored.
    resp_drain = imemresp_val & ((drop_cnt_q != '0) | (outstanding != '0));
    resp_drop  = imemresp_val & ~rst & ~redirect_val & (drop_cnt_q != '0);
    resp_fill  = imemresp_val & ~rst & ~redirect_val & (drop_cnt_q == '0)
               & (outstanding != '0);
  end

  // Next-state: redirect flushes everything, otherwise issue/fill/pop
  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    pc_d       = pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    drop_cnt_d = drop_cnt_q;
    filled_d   = filled_q;

    if (redirect_val) begin
      pc_d       = redirect_pc;
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      filled_d   = '0;
      // Every live request becomes a wrong-path drop; a response arriving now is already drained.
      drop_cnt_d = drop_cnt_q + outstanding - {{(PW-1){1'b0}}, resp_drain};
    end else begin
      if (req_fire) begin
        pc_d                = pc_q + 32'd4;
        alloc_d             = alloc_q + PTR_ONE;
        filled_d[alloc_idx] = 1'b0;
      end
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - PTR_ONE;
      end
      // alloc_idx and fill_idx cannot collide here: a fill needs outstanding != 0
      // and an issue needs count < DEPTH.
      if (resp_fill) begin
        filled_d[fill_idx] = 1'b1;
        fill_d             = fill_q + PTR_ONE;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pc_q       <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      drop_cnt_q <= '0;
      filled_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      drop_cnt_q <= drop_cnt_d;
      filled_q   <= filled_d;
    end
  end

  // Payload writes: PC at issue, instruction at fill
  always_ff @(posedge clk) begin
    // NOTE: payload arrays carry no reset; entry validity is tracked by filled_q alone.
    if (req_fire) begin
      pc_mem[alloc_idx] <= pc_q;
    end
    if (resp_fill) begin
      inst_mem[fill_idx] <= imemresp_data;
    end
  end

  a_occupancy_bound : assert property (@(posedge clk) disable iff (rst)
    occupancy <= DEPTH_W);

  a_resp_owed : assert property (@(posedge clk) disable iff (rst)
    imemresp_val |-> ((drop_cnt_q != '0) || (outstanding != '0)));

endmodule
